// File: rtl/evo_servo_ramp_pkg.sv
// evo_servo_ramp_pkg: shared types, field offsets and step arithmetic for evo_servo_ramp
package evo_servo_ramp_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, GAP} state_e;
  localparam int EN_BIT = 7;
  localparam int CHAN_LSB = 0;
  localparam int CHAN_W = 5;
  localparam int CTL_LSB = 0;
  localparam int PWL_LSB = 8;
  localparam int PWH_LSB = 16;
  localparam int DIS_LSB = 24;
  localparam logic [15:0] STEP_RST = 16'd10;
  // A disabled channel holds its position; the write only carries en=0.
  function automatic logic [15:0] ramp_next(input logic [15:0] cur, input logic [15:0] tgt,
                                            input logic [15:0] step, input logic en);
    logic [15:0] diff;
    diff = tgt >= cur ? tgt - cur : cur - tgt;
    return !en ? cur : (step == '0 || diff <= step) ? tgt : tgt > cur ? cur + step : cur - step;
  endfunction
  function automatic logic [31:0] wr_data(input logic [15:0] pw, input logic en, input logic [4:0] chan);
    logic [31:0] d;
    d = '0;
    d[DIS_LSB +: 3] = 3'b000;
    d[PWH_LSB +: 8] = pw[15:8];
    d[PWL_LSB +: 8] = pw[7:0];
    d[CTL_LSB + EN_BIT] = en;
    d[CTL_LSB + CHAN_LSB +: CHAN_W] = chan;
    return d;
  endfunction
endpackage

// File: rtl/evo_servo_ramp_if.sv
// evo_servo_ramp_if: Avalon-MM write-only bus between the ramp master and the evo_servo CSR
// Signals: avm_address, avm_write, avm_writedata (master->slave); avm_waitrequest (slave->master)
interface evo_servo_ramp_if #(parameter int AW = 12, parameter int DW = 32);
  logic [AW-1:0] avm_address;
  logic avm_write;
  logic [DW-1:0] avm_writedata;
  logic avm_waitrequest;
  modport master(output avm_address, avm_write, avm_writedata, input avm_waitrequest);
  modport slave(input avm_address, avm_write, avm_writedata, output avm_waitrequest);
endinterface

// File: rtl/evo_servo_ramp_tick.sv
// evo_servo_ramp_tick: divides en1mhz pulses by STEP_TICKS into a one-clock sweep strobe
// Ports: clk, reset (async, active-high), en1mhz_i (1 MHz enable), sweep_o (strobe on wrap)
module evo_servo_ramp_tick #(parameter int STEP_TICKS = 1000) (
  input  logic clk,
  input  logic reset,
  input  logic en1mhz_i,
  output logic sweep_o
);
  localparam int CW = $clog2(STEP_TICKS + 1);
  logic [CW-1:0] cnt_q;
  assign sweep_o = en1mhz_i && cnt_q == CW'(STEP_TICKS - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (en1mhz_i) cnt_q <= sweep_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/evo_servo_ramp.sv
// evo_servo_ramp: Avalon-MM master ramping each servo channel toward its target pulse width
// Ports: clk, reset (async, active-high), en1mhz, cfg_* (per-channel target/enable and global step),
//        avm (evo_servo_ramp_if master modport), busy_o (not IDLE).
// Optional EVO_SERVO_RAMP_DONE_EN adds done_o (sticky per-channel at-target flags) and done_irq_o.
module evo_servo_ramp
  import evo_servo_ramp_pkg::*;
#(
  parameter int NUM_SERVOS = 32,
  parameter int CSR_AWIDTH = 12,
  parameter int CSR_DWIDTH = 32,
  parameter logic [CSR_AWIDTH-1:0] EVO_SERVO_ADDR = '0,
  parameter int STEP_TICKS = 1000,
  parameter int WR_GAP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en1mhz,
  input  logic cfg_we,
  input  logic [4:0] cfg_chan,
  input  logic cfg_en,
  input  logic [15:0] cfg_target,
  input  logic cfg_step_we,
  input  logic [15:0] cfg_step,
  evo_servo_ramp_if.master avm,
`ifdef EVO_SERVO_RAMP_DONE_EN
  output logic [NUM_SERVOS-1:0] done_o,
  output logic done_irq_o,
`endif
  output logic busy_o
);
  localparam int IW = NUM_SERVOS > 1 ? $clog2(NUM_SERVOS) : 1;
  state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [15:0] gcnt_q, gcnt_d, nxt_q, nxt_d, step_q;
  logic en_iss_q, en_iss_d, pend_q, sweep, take, acc, need, last, cfg_ok;
  logic [15:0] cur_q [NUM_SERVOS];
  logic [15:0] tgt_q [NUM_SERVOS];
  logic [NUM_SERVOS-1:0] en_q, dirty_q;
  logic [IW-1:0] ii, ci;
  evo_servo_ramp_tick #(.STEP_TICKS(STEP_TICKS)) u_tick (.clk(clk), .reset(reset), .en1mhz_i(en1mhz), .sweep_o(sweep));
  assign ii = idx_q[IW-1:0];
  assign ci = cfg_chan[IW-1:0];
  assign cfg_ok = cfg_we && 32'(cfg_chan) < NUM_SERVOS;
  assign last = idx_q == 5'(NUM_SERVOS - 1);
  assign need = dirty_q[ii] || (en_q[ii] && cur_q[ii] != tgt_q[ii]);
  assign take = state_q == IDLE && pend_q;
  assign acc = state_q == ISSUE && !avm.avm_waitrequest;
  // Outputs decode straight from registered state so reset drops the write without waiting for a clock.
  assign avm.avm_write = state_q == ISSUE;
  assign avm.avm_address = state_q == ISSUE ? EVO_SERVO_ADDR : '0;
  assign avm.avm_writedata = state_q == ISSUE ? CSR_DWIDTH'(wr_data(nxt_q, en_iss_q, idx_q)) : '0;
  assign busy_o = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    gcnt_d = gcnt_q;
    nxt_d = nxt_q;
    en_iss_d = en_iss_q;
    case (state_q)
      IDLE: if (pend_q) begin
        idx_d = '0;
        state_d = SCAN;
      end
      SCAN: if (need) begin
        nxt_d = ramp_next(cur_q[ii], tgt_q[ii], step_q, en_q[ii]);
        en_iss_d = en_q[ii];
        state_d = ISSUE;
      end else begin
        idx_d = idx_q + 5'd1;
        state_d = last ? IDLE : SCAN;
      end
      ISSUE: if (!avm.avm_waitrequest) begin
        gcnt_d = 16'(WR_GAP - 1);
        state_d = GAP;
      end
      default: if (gcnt_q <= 16'd1) begin
        idx_d = idx_q + 5'd1;
        state_d = last ? IDLE : SCAN;
      end else gcnt_d = gcnt_q - 16'd1;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      gcnt_q <= '0;
      nxt_q <= '0;
      en_iss_q <= 1'b0;
      pend_q <= 1'b0;
      step_q <= STEP_RST;
      en_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < NUM_SERVOS; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      gcnt_q <= gcnt_d;
      nxt_q <= nxt_d;
      en_iss_q <= en_iss_d;
      pend_q <= pend_q ? !take : sweep;
      if (cfg_step_we) step_q <= cfg_step;
      if (acc) begin
        cur_q[ii] <= nxt_q;
        dirty_q[ii] <= 1'b0;
      end
      // Placed after the acceptance update so a same-cycle reconfiguration keeps dirty set.
      if (cfg_ok) begin
        tgt_q[ci] <= cfg_target;
        en_q[ci] <= cfg_en;
        dirty_q[ci] <= 1'b1;
      end
    end
`ifdef EVO_SERVO_RAMP_DONE_EN
  logic [NUM_SERVOS-1:0] done_q, done_d, set_v, clr_v;
  logic irq_q;
  always_comb begin
    set_v = '0;
    clr_v = '0;
    set_v[ii] = acc && en_iss_q && nxt_q == tgt_q[ii];
    clr_v[ci] = cfg_ok;
    done_d = (done_q | set_v) & ~clr_v;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      done_q <= '0;
      irq_q <= 1'b0;
    end else begin
      done_q <= done_d;
      irq_q <= |(done_d & ~done_q);
    end
  assign done_o = done_q;
  assign done_irq_o = irq_q;
`endif
endmodule

// File: tb/tb_evo_servo_ramp.sv
// tb_evo_servo_ramp: directed table-driven bench for evo_servo_ramp
module tb_evo_servo_ramp;
  localparam int NS = 8;
  localparam int TICKS = 4;
  localparam int GAPC = 4;
  typedef struct {
    logic sw;
    logic [15:0] step;
    int chan;
    logic en;
    logic [15:0] tgt;
    int n;
    logic [31:0] first;
    logic [31:0] last;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, en1mhz = 1'b0, cfg_we = 1'b0, cfg_en = 1'b0, cfg_step_we = 1'b0;
  logic [4:0] cfg_chan = '0;
  logic [15:0] cfg_target = '0, cfg_step = '0;
  logic busy_o;
  int checks = 0, fails = 0, addr_bad = 0, n;
  logic [31:0] wq[$];
  logic [31:0] hd;
  logic [11:0] ha;
  vec_t v[8];
`ifdef EVO_SERVO_RAMP_DONE_EN
  logic [NS-1:0] done_o;
  logic done_irq_o;
  int irq_cnt = 0;
`endif
  evo_servo_ramp_if #(.AW(12), .DW(32)) bus();
  evo_servo_ramp #(.NUM_SERVOS(NS), .STEP_TICKS(TICKS), .WR_GAP(GAPC)) dut (
    .clk(clk), .reset(reset), .en1mhz(en1mhz), .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_en(cfg_en),
    .cfg_target(cfg_target), .cfg_step_we(cfg_step_we), .cfg_step(cfg_step), .avm(bus),
`ifdef EVO_SERVO_RAMP_DONE_EN
    .done_o(done_o), .done_irq_o(done_irq_o),
`endif
    .busy_o(busy_o));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.avm_write && !bus.avm_waitrequest) begin
      wq.push_back(bus.avm_writedata);
      if (bus.avm_address != 12'h0) addr_bad++;
    end
`ifdef EVO_SERVO_RAMP_DONE_EN
    if (done_irq_o) irq_cnt++;
`endif
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask
  task automatic cfg(input logic sw, input logic [15:0] st, input int ch, input logic en, input logic [15:0] tg);
    @(posedge clk); #1;
    cfg_step_we = sw; cfg_step = st; cfg_we = 1'b1; cfg_chan = 5'(ch); cfg_en = en; cfg_target = tg;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_step_we = 1'b0;
  endtask
  task automatic wait_write(input string name);
    int k;
    k = 0;
    while (!bus.avm_write && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, {31'b0, bus.avm_write}, 32'd1);
  endtask
  initial begin
    v[0] = '{1'b0, 16'd0,   7,  1'b1, 16'd25,   3,  32'h0000_0A87, 32'h0000_1987};
    v[1] = '{1'b1, 16'd100, 3,  1'b1, 16'd1500, 15, 32'h0000_6483, 32'h0005_DC83};
    v[2] = '{1'b1, 16'd0,   0,  1'b1, 16'd2000, 1,  32'h0007_D080, 32'h0007_D080};
    v[3] = '{1'b1, 16'd0,   5,  1'b1, 16'd1200, 1,  32'h0004_B085, 32'h0004_B085};
    v[4] = '{1'b1, 16'd0,   5,  1'b0, 16'd1200, 1,  32'h0004_B005, 32'h0004_B005};
    v[5] = '{1'b1, 16'd500, 3,  1'b1, 16'd200,  3,  32'h0003_E883, 32'h0000_C883};
    v[6] = '{1'b1, 16'd7,   4,  1'b0, 16'd300,  1,  32'h0000_0004, 32'h0000_0004};
    v[7] = '{1'b1, 16'd0,   40, 1'b1, 16'd900,  0,  32'h0, 32'h0};
    bus.avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset avm_write", {31'b0, bus.avm_write}, 32'd0);
    check("reset avm_address", {20'b0, bus.avm_address}, 32'd0);
    check("reset avm_writedata", bus.avm_writedata, 32'd0);
    check("reset busy_o", {31'b0, busy_o}, 32'd0);
`ifdef EVO_SERVO_RAMP_DONE_EN
    check("reset done_o", {24'b0, done_o}, 32'd0);
    check("reset done_irq_o", {31'b0, done_irq_o}, 32'd0);
`endif
    reset = 1'b0;
    en1mhz = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wq.delete();
      addr_bad = 0;
      cfg(v[i].sw, v[i].step, v[i].chan, v[i].en, v[i].tgt);
      repeat (400) @(posedge clk);
      #1;
      check($sformatf("vec%0d write count", i), wq.size(), v[i].n);
      if (v[i].n > 0) begin
        check($sformatf("vec%0d first data", i), wq.size() > 0 ? wq[0] : 32'hx, v[i].first);
        check($sformatf("vec%0d last data", i), wq.size() > 0 ? wq[wq.size()-1] : 32'hx, v[i].last);
      end
      check($sformatf("vec%0d address", i), addr_bad, 0);
      if (i == 1)
        for (int k = 0; k < 15 && k < wq.size(); k++)
          check($sformatf("ramp step %0d pw", k), {16'b0, wq[k][23:8]}, 32'(100 * (k + 1)));
    end
    wq.delete();
    bus.avm_waitrequest = 1'b1;
`ifdef EVO_SERVO_RAMP_DONE_EN
    check("done ch1 before ramp", {31'b0, done_o[1]}, 32'd0);
    irq_cnt = 0;
`endif
    cfg(1'b1, 16'd10, 1, 1'b1, 16'd30);
    wait_write("stall write seen");
    ha = bus.avm_address;
    hd = bus.avm_writedata;
    check("stall data", hd, 32'h0000_0A81);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("stall hold write %0d", k), {31'b0, bus.avm_write}, 32'd1);
      check($sformatf("stall hold data %0d", k), bus.avm_writedata, hd);
      check($sformatf("stall hold addr %0d", k), {20'b0, bus.avm_address}, {20'b0, ha});
    end
    bus.avm_waitrequest = 1'b0;
    @(posedge clk); #1;
    n = 0;
    while (!bus.avm_write && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(n >= GAPC && n < 200)) begin
      fails++;
      $display("FAIL write gap: %0d clocks, required >= %0d and a following write", n, GAPC);
    end
    repeat (300) @(posedge clk);
    #1;
    check("stall ramp count", wq.size(), 3);
    check("stall ramp last", wq.size() > 0 ? wq[wq.size()-1] : 32'hx, 32'h0000_1E81);
`ifdef EVO_SERVO_RAMP_DONE_EN
    check("done ch1 set", {31'b0, done_o[1]}, 32'd1);
    check("done irq pulses", irq_cnt, 1);
    cfg(1'b0, 16'd0, 1, 1'b1, 16'd30);
    check("done ch1 cleared", {31'b0, done_o[1]}, 32'd0);
`endif
    repeat (200) @(posedge clk);
    wq.delete();
    bus.avm_waitrequest = 1'b1;
    cfg(1'b1, 16'd100, 2, 1'b1, 16'd400);
    wait_write("simul write seen");
    check("simul first data", bus.avm_writedata, 32'h0000_6482);
    bus.avm_waitrequest = 1'b0;
    cfg_we = 1'b1; cfg_chan = 5'd2; cfg_en = 1'b1; cfg_target = 16'd800;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    check("simul count", wq.size(), 8);
    check("simul second data", wq.size() > 1 ? wq[1] : 32'hx, 32'h0000_C882);
    check("simul last data", wq.size() > 0 ? wq[wq.size()-1] : 32'hx, 32'h0003_2082);
    bus.avm_waitrequest = 1'b1;
    cfg(1'b1, 16'd0, 6, 1'b1, 16'd100);
    wait_write("reset-test write seen");
    #2 reset = 1'b1;
    #1;
    check("async reset avm_write", {31'b0, bus.avm_write}, 32'd0);
    check("async reset avm_writedata", bus.avm_writedata, 32'd0);
    check("async reset busy_o", {31'b0, busy_o}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
